// File: rtl/capture_write_controller_pkg.sv
// Shared definitions for the logic-analyzer capture write controller:
// default buffer address width and the FSM state encodings.
// Optional build macro honoured by the design: TRIG_EDGE_TRIGGER_EN.
package capture_write_controller_pkg;

   localparam int ADDR_WIDTH_DEFAULT = 4;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      FILL      = 3'd1,
      WAIT_TRIG = 3'd2,
      POST      = 3'd3,
      DONE      = 3'd4
   } state_t;

endpackage

// File: rtl/capture_write_controller_trigger_comparator.sv
// Masked trigger pattern comparator. A sample matches when every bit
// selected by trig_mask equals trig_value. With TRIG_EDGE_TRIGGER_EN
// defined, match is only raised on a rising edge of the pattern across
// consecutive written samples.
module trigger_comparator
   import capture_write_controller_pkg::*;
#(
   parameter int DATA_WIDTH = 8
) (
`ifdef TRIG_EDGE_TRIGGER_EN
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  restart,
   input  logic                  update,
`endif
   input  logic [DATA_WIDTH-1:0] sample,
   input  logic [DATA_WIDTH-1:0] trig_value,
   input  logic [DATA_WIDTH-1:0] trig_mask,
   output logic                  match
);

   logic level;

   assign level = (((sample ^ trig_value) & trig_mask) == '0);

`ifdef TRIG_EDGE_TRIGGER_EN
   logic prev;

   // Remember whether the previously written sample matched; forgotten at capture start.
   always_ff @(posedge clk) begin
      if (!reset) begin
         prev <= 1'b0;
      end else if (restart) begin
         prev <= 1'b0;
      end else if (update) begin
         prev <= level;
      end
   end

   assign match = level & ~prev;
`else
   assign match = level;
`endif

endmodule

// File: rtl/capture_write_controller.sv
// Write-side sequencer of the logic-analyzer sample buffer. After arm it
// streams samples into the circular buffer, pre-fills the pre-trigger
// window, waits for a masked trigger, stores POST_TRIG samples counted from
// the trigger sample and freezes with waddr on the last written sample.
// Optional build macro: TRIG_EDGE_TRIGGER_EN (edge- instead of level-trigger).
module capture_write_controller
   import capture_write_controller_pkg::*;
#(
   parameter int ADDR_WIDTH = ADDR_WIDTH_DEFAULT,
   parameter int DATA_WIDTH = 8,
   parameter int POST_TRIG  = 2 ** (ADDR_WIDTH - 1)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  arm,
   input  logic                  clear,
   input  logic [DATA_WIDTH-1:0] sample_in,
   input  logic [DATA_WIDTH-1:0] trig_value,
   input  logic [DATA_WIDTH-1:0] trig_mask,
   output logic                  write_enable,
   output logic [ADDR_WIDTH-1:0] waddr,
   output logic [DATA_WIDTH-1:0] wdata,
   output logic                  triggered,
   output logic                  capture_done
);

   localparam int                DEPTH     = 2 ** ADDR_WIDTH;
   localparam int                CNT_W     = ADDR_WIDTH + 1;
   localparam logic [CNT_W-1:0]  PRE_CNT   = CNT_W'(DEPTH - POST_TRIG);
   localparam logic [CNT_W-1:0]  POST_CNT  = CNT_W'(POST_TRIG);

   state_t                state, state_next;
   logic [CNT_W-1:0]      fill_cnt, fill_next;
   logic [CNT_W-1:0]      post_cnt, post_next;
   logic [ADDR_WIDTH-1:0] waddr_next;
   logic                  we_next, trig_next, done_next;
   logic                  match;

`ifdef TRIG_EDGE_TRIGGER_EN
   logic restart;

   assign restart = (state == IDLE) & arm & ~clear;
`endif

   // The comparator looks at the registered sample, i.e. the one being written.
   trigger_comparator #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_trig (
`ifdef TRIG_EDGE_TRIGGER_EN
      .clk        (clk),
      .reset      (reset),
      .restart    (restart),
      .update     (write_enable),
`endif
      .sample     (wdata),
      .trig_value (trig_value),
      .trig_mask  (trig_mask),
      .match      (match)
   );

   // State register.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next state and next register values; clear overrides every other event.
   always_comb begin
      state_next = state;
      waddr_next = waddr;
      fill_next  = fill_cnt;
      post_next  = post_cnt;
      we_next    = 1'b0;
      trig_next  = triggered;
      done_next  = capture_done;
      if (clear) begin
         state_next = IDLE;
         trig_next  = 1'b0;
         done_next  = 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (arm) begin
                  state_next = FILL;
                  waddr_next = '0;
                  fill_next  = '0;
                  we_next    = 1'b1;
               end
            end
            FILL: begin
               fill_next  = fill_cnt + 1'b1;
               waddr_next = waddr + 1'b1;
               we_next    = 1'b1;
               if (fill_cnt + 1'b1 == PRE_CNT) begin
                  state_next = WAIT_TRIG;
               end
            end
            WAIT_TRIG: begin
               if (match) begin
                  trig_next = 1'b1;
                  post_next = CNT_W'(1);
                  if (POST_TRIG == 1) begin
                     state_next = DONE;
                     done_next  = 1'b1;
                  end else begin
                     state_next = POST;
                     waddr_next = waddr + 1'b1;
                     we_next    = 1'b1;
                  end
               end else begin
                  waddr_next = waddr + 1'b1;
                  we_next    = 1'b1;
               end
            end
            POST: begin
               post_next = post_cnt + 1'b1;
               if (post_cnt + 1'b1 == POST_CNT) begin
                  state_next = DONE;
                  done_next  = 1'b1;
               end else begin
                  waddr_next = waddr + 1'b1;
                  we_next    = 1'b1;
               end
            end
            DONE: begin
               state_next = DONE;
            end
            default: begin
               state_next = IDLE;
            end
         endcase
      end
   end

   // Registered outputs and counters; wdata is the input sample delayed one clock.
   always_ff @(posedge clk) begin
      if (!reset) begin
         waddr        <= '0;
         wdata        <= '0;
         write_enable <= 1'b0;
         triggered    <= 1'b0;
         capture_done <= 1'b0;
         fill_cnt     <= '0;
         post_cnt     <= '0;
      end else begin
         waddr        <= waddr_next;
         wdata        <= sample_in;
         write_enable <= we_next;
         triggered    <= trig_next;
         capture_done <= done_next;
         fill_cnt     <= fill_next;
         post_cnt     <= post_next;
      end
   end

endmodule

// File: tb/tb_capture_write_controller.sv
// Self-checking bench for capture_write_controller (ADDR_WIDTH=4,
// DATA_WIDTH=8, POST_TRIG=4). Honours TRIG_EDGE_TRIGGER_EN for expectations.
module tb_capture_write_controller;

   localparam int AW    = 4;
   localparam int DW    = 8;
   localparam int PT    = 4;
   localparam int DEPTH = 16;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          arm = 1'b0;
   logic          clear = 1'b0;
   logic [DW-1:0] sample_in = '0;
   logic [DW-1:0] trig_value = '0;
   logic [DW-1:0] trig_mask = '0;
   logic          write_enable;
   logic [AW-1:0] waddr;
   logic [DW-1:0] wdata;
   logic          triggered;
   logic          capture_done;

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct {
      string         name;
      int            kind;    // 0: background + hits, 1: counting, 2: held 0x14 with one 0x00 at k=15
      logic [DW-1:0] tv;
      logic [DW-1:0] tm;
      logic [DW-1:0] hitv;
      int            h1;
      int            h2;
      int            trig_k;  // sample index that fires, -1 = none
      int            ncyc;
   } vec_t;

   typedef struct {
      logic [AW-1:0] a;
      logic [DW-1:0] d;
   } wr_t;

   wr_t  sb[$];
   vec_t vecs[7];

   capture_write_controller #(
      .ADDR_WIDTH (AW),
      .DATA_WIDTH (DW),
      .POST_TRIG  (PT)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .arm          (arm),
      .clear        (clear),
      .sample_in    (sample_in),
      .trig_value   (trig_value),
      .trig_mask    (trig_mask),
      .write_enable (write_enable),
      .waddr        (waddr),
      .wdata        (wdata),
      .triggered    (triggered),
      .capture_done (capture_done)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [DW-1:0] pat(input vec_t v, input int k);
      logic [DW-1:0] r;
      case (v.kind)
         1:       r = DW'(k);
         2:       r = (k == 15) ? 8'h00 : 8'h14;
         default: r = (k == v.h1 || k == v.h2) ? v.hitv : (8'hA0 | DW'(k % 16));
      endcase
      return r;
   endfunction

   task automatic run_vec(input vec_t v);
      int  last;
      bit  exp_trig, exp_done;
      wr_t w;
      last = (v.trig_k >= 0) ? v.trig_k + PT - 1 : 1 << 30;
      trig_value = v.tv;
      trig_mask  = v.tm;
      for (int k = 0; k < v.ncyc; k++) begin
         sample_in = pat(v, k);
         arm       = (k == 0);
         if (k <= last) begin
            w.a = AW'(k % DEPTH);
            w.d = pat(v, k);
            sb.push_back(w);
         end
         tick();
         arm = 1'b0;
         if (write_enable) begin
            if (sb.size() == 0) begin
               check({v.name, "/extra_write"}, 1, 0);
            end else begin
               w = sb.pop_front();
               check({v.name, "/waddr"}, int'(waddr), int'(w.a));
               check({v.name, "/wdata"}, int'(wdata), int'(w.d));
            end
         end else if (sb.size() != 0) begin
            check({v.name, "/missing_write"}, 0, 1);
            sb.delete();
         end
         exp_trig = (v.trig_k >= 0) && (k >= v.trig_k + 1);
         exp_done = (v.trig_k >= 0) && (k >= last + 1);
         check({v.name, "/triggered"}, int'(triggered), int'(exp_trig));
         check({v.name, "/capture_done"}, int'(capture_done), int'(exp_done));
         if (exp_done) break;
      end
      if (v.trig_k >= 0) begin
         check({v.name, "/final_waddr"}, int'(waddr), last % DEPTH);
         arm = 1'b1;
         tick();
         arm = 1'b0;
         check({v.name, "/arm_in_done_we"}, int'(write_enable), 0);
         check({v.name, "/arm_in_done_done"}, int'(capture_done), 1);
         check({v.name, "/arm_in_done_waddr"}, int'(waddr), last % DEPTH);
         clear = 1'b1;
         tick();
         clear = 1'b0;
         check({v.name, "/clear_done"}, int'(capture_done), 0);
         check({v.name, "/clear_trig"}, int'(triggered), 0);
         check({v.name, "/clear_waddr_kept"}, int'(waddr), last % DEPTH);
      end else begin
         clear = 1'b1;
         tick();
         clear = 1'b0;
         check({v.name, "/clear_we"}, int'(write_enable), 0);
      end
      sb.delete();
   endtask

   initial begin
      vecs[0] = '{"basic_count", 1, 8'h14, 8'hFF, 8'h00, -1, -1, 20, 40};
      vecs[1] = '{"early_ignored", 0, 8'h14, 8'hFF, 8'h14, 5, 30, 30, 50};
      vecs[2] = '{"mask_low_nibble", 0, 8'h14, 8'h0F, 8'h00, -1, -1, 20, 40};
      vecs[3] = '{"mask_high_nibble", 0, 8'h14, 8'hF0, 8'h1F, 15, -1, 15, 40};
      vecs[4] = '{"last_fill_ignored", 0, 8'h14, 8'hFF, 8'h14, 11, 13, 13, 40};
      vecs[5] = '{"wrap_no_trigger", 0, 8'h14, 8'hFF, 8'h00, -1, -1, -1, 100};
`ifdef TRIG_EDGE_TRIGGER_EN
      vecs[6] = '{"held_pattern", 2, 8'h14, 8'hFF, 8'h00, -1, -1, 16, 40};
`else
      vecs[6] = '{"held_pattern", 2, 8'h14, 8'hFF, 8'h00, -1, -1, 12, 40};
`endif

      // Reset held for two cycles
      reset = 1'b0;
      tick();
      tick();
      check("reset/waddr", int'(waddr), 0);
      check("reset/we", int'(write_enable), 0);
      check("reset/done", int'(capture_done), 0);
      check("reset/trig", int'(triggered), 0);
      reset = 1'b1;
      tick();

      foreach (vecs[i]) run_vec(vecs[i]);

      // Match-everything mask: level fires on first WAIT_TRIG write, edge never fires
`ifdef TRIG_EDGE_TRIGGER_EN
      run_vec('{"mask_zero", 0, 8'h14, 8'h00, 8'h00, -1, -1, -1, 40});
`else
      run_vec('{"mask_zero", 0, 8'h14, 8'h00, 8'h00, -1, -1, 12, 40});
`endif

      // clear one cycle after triggered, then re-arm
      trig_value = 8'h14;
      trig_mask  = 8'hFF;
      for (int k = 0; k <= 21; k++) begin
         sample_in = DW'(k);
         arm       = (k == 0);
         tick();
         arm = 1'b0;
      end
      check("clear_post/triggered_before", int'(triggered), 1);
      clear     = 1'b1;
      sample_in = 8'd22;
      tick();
      clear = 1'b0;
      check("clear_post/we", int'(write_enable), 0);
      check("clear_post/trig", int'(triggered), 0);
      check("clear_post/done", int'(capture_done), 0);
      tick();
      check("clear_post/idle_we", int'(write_enable), 0);
      arm       = 1'b1;
      sample_in = 8'hAA;
      tick();
      arm = 1'b0;
      check("rearm/we", int'(write_enable), 1);
      check("rearm/waddr", int'(waddr), 0);
      check("rearm/wdata", int'(wdata), 8'hAA);

      // Reset in the middle of FILL aborts with no further writes
      for (int k = 0; k < 4; k++) begin
         sample_in = DW'(k + 1);
         tick();
      end
      reset = 1'b0;
      tick();
      reset = 1'b1;
      check("mid_reset/we", int'(write_enable), 0);
      check("mid_reset/waddr", int'(waddr), 0);
      check("mid_reset/wdata", int'(wdata), 0);
      check("mid_reset/trig", int'(triggered), 0);
      for (int k = 0; k < 3; k++) begin
         tick();
         check("mid_reset/no_write", int'(write_enable), 0);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
